nvram_arbiter: RTL and testbench
================================

NVRAM_ARBITER -- requirements
Module: nvram_arbiter

Interface
REQ-001 clk30  input  1  system clock; every register samples on its rising edge.
REQ-002 reset  input  1  reset, asynchronous, active-high.
REQ-003 cpu_req  input  1  CPU access request (NVRAM chip select with a data strobe); held until cpu_ack.
REQ-004 cpu_we  input  1  CPU write when 1, read when 0; sampled at grant.
REQ-005 cpu_addr  input  13  CPU byte address within the 8 KiB NVRAM.
REQ-006 cpu_din  input  8  CPU write data (upper data byte).
REQ-007 cpu_dout  output  8  CPU read data; valid while cpu_ack=1.
REQ-008 cpu_ack  output  1  one-cycle CPU bus acknowledge.
REQ-009 hps_req, hps_we, hps_addr[12:0], hps_din[7:0]  input  HPS backup/restore port; same semantics as the CPU port.
REQ-010 hps_dout  output  8  / hps_ack  output  1  HPS read data and one-cycle acknowledge.
REQ-011 allow_cpu  input  1  when 0, CPU requests are not granted.
REQ-012 ram_addr  output  13  / ram_we  output  1  / ram_din  output  8  registered controls to a single-port synchronous RAM.
REQ-013 ram_q  input  8  RAM read data, valid one cycle after ram_addr is presented.
REQ-014 cpu_changed  output  1  one-cycle pulse per completed CPU write.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-016 IDLE: the arbiter SHALL select an eligible requester and load ram_addr, ram_din and ram_we (=we) from it, then go to ACCESS. With no eligible requester it SHALL stay in IDLE.
REQ-017 A requester SHALL be eligible when its req=1 and its served flag=0. The CPU SHALL also require allow_cpu=1.
REQ-018 When both requesters are eligible, the grant SHALL go to the one not granted last (round-robin). The CPU SHALL win the first tie after reset.
REQ-019 ACCESS: ram_we SHALL return to 0 at the next edge; go to DONE.
REQ-020 DONE: capture ram_q into the granted port's dout, pulse that port's ack for exactly one cycle, set its served flag, and return to IDLE.
REQ-021 Request-to-ack latency SHALL be 3 cycles from the first IDLE cycle with an eligible request. ram_we SHALL be high for exactly 1 cycle per write.
REQ-022 A served flag SHALL clear on the first cycle its req=0, so each held request is acknowledged only once.
REQ-023 Write data SHALL also appear on dout (read-after-write value) during the write ack.
REQ-024 cpu_changed SHALL pulse in the same cycle as cpu_ack for CPU writes only; HPS writes SHALL never pulse it.
REQ-025 Deassertion of req between grant and ack SHALL NOT abort the cycle; the ack is still issued.
REQ-026 allow_cpu falling after a CPU grant SHALL NOT abort that CPU cycle.
REQ-027 Unacknowledged outputs SHALL hold their previous dout value; ack=0.

Reset
REQ-028 Reset assertion SHALL immediately force: state=IDLE, ram_we=0, ram_addr=0, ram_din=0, cpu_ack=0, hps_ack=0, cpu_dout=0, hps_dout=0, cpu_changed=0, both served flags=0, last-grant=HPS.
REQ-029 Reset mid-access SHALL drop the pending ack; no ack is issued for that request after reset release.

Configuration
REQ-030 NVRAM_DIRTY_TRACK_EN defined: add input dirty_clr (1) and output dirty (1). dirty sets on any completed CPU write, clears on dirty_clr, and set wins when both occur in the same cycle. dirty resets to 0.
REQ-031 NVRAM_DIRTY_TRACK_EN undefined: the dirty_clr and dirty ports and the dirty logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-032 CPU write addr 0x0123, data 0xA5, allow_cpu=1 -> ram_we=1 for 1 cycle with ram_addr=0x0123; cpu_ack and cpu_changed pulse 3 cycles after req.
REQ-033 CPU read 0x0123 after the REQ-032 write -> cpu_dout=0xA5 while cpu_ack=1; cpu_changed stays 0.
REQ-034 cpu_req and hps_req rise in the same cycle after reset -> CPU acked first, HPS acked 3 cycles later. A repeated tie with fresh requests -> HPS first.
REQ-035 cpu_req held high for 20 cycles -> exactly one cpu_ack. Drop req for 1 cycle and reassert -> a second ack.
REQ-036 allow_cpu=0 with cpu_req=1 while HPS writes 0x1FFF=0x3C -> only hps_ack; raise allow_cpu -> cpu_ack follows within 3 cycles.
REQ-037 Reset pulsed during ACCESS of a CPU write -> ram_we=0 immediately, no cpu_ack. With NVRAM_DIRTY_TRACK_EN, a write then dirty_clr in the ack cycle -> dirty=1.

Source files
------------

// File: rtl/nvram_arbiter.sv
// nvram_arbiter: two-port (CPU / HPS) arbiter in front of a single-port
// synchronous 8 KiB NVRAM.
//
// Each access takes three cycles: grant (IDLE), RAM access (ACCESS) and
// acknowledge (DONE). Simultaneous requests are resolved round-robin. A
// served flag per port ensures that a request held high is acknowledged
// only once.
//
// Ports
//   clk30, reset                 clock and asynchronous active-high reset
//   cpu_req/we/addr/din          CPU request, direction, byte address, write data
//   cpu_dout, cpu_ack            CPU read data and one-cycle acknowledge
//   hps_req/we/addr/din          HPS backup/restore request (same semantics)
//   hps_dout, hps_ack            HPS read data and one-cycle acknowledge
//   allow_cpu                    gates new CPU grants
//   ram_addr, ram_we, ram_din    registered RAM controls
//   ram_q                        RAM read data (one cycle after ram_addr)
//   cpu_changed                  one-cycle pulse per completed CPU write
//   dirty_clr, dirty             present only with NVRAM_DIRTY_TRACK_EN defined;
//                                sticky "CPU has written" flag and its clear
module nvram_arbiter (
  input  logic        clk30,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        hps_req,
  input  logic        hps_we,
  input  logic [12:0] hps_addr,
  input  logic [7:0]  hps_din,
  output logic [7:0]  hps_dout,
  output logic        hps_ack,
  input  logic        allow_cpu,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_q,
  output logic        cpu_changed
`ifdef NVRAM_DIRTY_TRACK_EN
  ,
  input  logic        dirty_clr,
  output logic        dirty
`endif
);

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic          gnt_hps_q;     // port owning the current access
  logic          wr_q;          // current access is a write
  logic          last_hps_q;    // HPS won the most recent contested grant
  logic          cpu_served_q, cpu_served_d;
  logic          hps_served_q, hps_served_d;
  logic [AW-1:0] ram_addr_q;
  logic          ram_we_q;
  logic [DW-1:0] ram_din_q;
  logic [DW-1:0] cpu_dout_q;
  logic [DW-1:0] hps_dout_q;
  logic          cpu_ack_q;
  logic          hps_ack_q;
  logic          cpu_changed_q;

  logic          cpu_elig_c;
  logic          hps_elig_c;
  logic          pick_hps_c;
  logic          done_c;
  logic [DW-1:0] rd_data_c;

  // Eligibility, round-robin pick and acknowledge data
  always_comb begin
    cpu_elig_c = cpu_req & ~cpu_served_q & allow_cpu;
    hps_elig_c = hps_req & ~hps_served_q;
    // HPS wins when alone, or on a tie when the CPU won the previous tie
    pick_hps_c = hps_elig_c & (~cpu_elig_c | ~last_hps_q);
    done_c     = (state_q == ST_DONE);
    // Writes return the written byte rather than the RAM's read-during-write value
    rd_data_c  = wr_q ? ram_din_q : ram_q;
  end

  // Served flags: set on the acknowledge, cleared whenever req is low
  always_comb begin
    cpu_served_d = cpu_served_q;
    hps_served_d = hps_served_q;
    if (done_c && !gnt_hps_q) cpu_served_d = 1'b1;
    if (done_c &&  gnt_hps_q) hps_served_d = 1'b1;
    if (!cpu_req) cpu_served_d = 1'b0;
    if (!hps_req) hps_served_d = 1'b0;
  end

  always_ff @(posedge clk30 or posedge reset) begin
    if (reset) begin
      cpu_served_q <= 1'b0;
      hps_served_q <= 1'b0;
    end else begin
      cpu_served_q <= cpu_served_d;
      hps_served_q <= hps_served_d;
    end
  end

  // Access sequencer with registered RAM controls and port responses
  always_ff @(posedge clk30 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gnt_hps_q     <= 1'b0;
      wr_q          <= 1'b0;
      last_hps_q    <= 1'b1;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_din_q     <= '0;
      cpu_dout_q    <= '0;
      hps_dout_q    <= '0;
      cpu_ack_q     <= 1'b0;
      hps_ack_q     <= 1'b0;
      cpu_changed_q <= 1'b0;
    end else begin
      cpu_ack_q     <= 1'b0;
      hps_ack_q     <= 1'b0;
      cpu_changed_q <= 1'b0;
      ram_we_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_elig_c || hps_elig_c) begin
            gnt_hps_q <= pick_hps_c;
            // Priority only rotates when both ports actually contend
            if (cpu_elig_c && hps_elig_c) last_hps_q <= pick_hps_c;
            if (pick_hps_c) begin
              ram_addr_q <= hps_addr;
              ram_din_q  <= hps_din;
              ram_we_q   <= hps_we;
              wr_q       <= hps_we;
            end else begin
              ram_addr_q <= cpu_addr;
              ram_din_q  <= cpu_din;
              ram_we_q   <= cpu_we;
              wr_q       <= cpu_we;
            end
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (gnt_hps_q) begin
            hps_dout_q <= rd_data_c;
            hps_ack_q  <= 1'b1;
          end else begin
            cpu_dout_q    <= rd_data_c;
            cpu_ack_q     <= 1'b1;
            cpu_changed_q <= wr_q;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NVRAM_DIRTY_TRACK_EN
  logic dirty_q;

  // Sticky dirty flag; a write completing in the clear cycle keeps it set
  always_ff @(posedge clk30 or posedge reset) begin
    if (reset) begin
      dirty_q <= 1'b0;
    end else if (cpu_changed_q) begin
      dirty_q <= 1'b1;
    end else if (dirty_clr) begin
      dirty_q <= 1'b0;
    end
  end

  assign dirty = dirty_q;
`endif

  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_din     = ram_din_q;
  assign cpu_dout    = cpu_dout_q;
  assign hps_dout    = hps_dout_q;
  assign cpu_ack     = cpu_ack_q;
  assign hps_ack     = hps_ack_q;
  assign cpu_changed = cpu_changed_q;

endmodule

// File: tb/tb_nvram_arbiter.sv
// tb_nvram_arbiter: self-checking bench for nvram_arbiter.
// A transaction-timeline model predicts every output each cycle; directed
// scenarios add hand-computed literal checks.
module tb_nvram_arbiter;

  logic        clk30 = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        hps_req = 1'b0, hps_we = 1'b0;
  logic [12:0] hps_addr = '0;
  logic [7:0]  hps_din = '0;
  logic [7:0]  hps_dout;
  logic        hps_ack;
  logic        allow_cpu = 1'b1;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_q = '0;
  logic        cpu_changed;
`ifdef NVRAM_DIRTY_TRACK_EN
  logic        dirty_clr = 1'b0;
  logic        dirty;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  nvram_arbiter dut (
    .clk30(clk30), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .hps_req(hps_req), .hps_we(hps_we), .hps_addr(hps_addr), .hps_din(hps_din),
    .hps_dout(hps_dout), .hps_ack(hps_ack),
    .allow_cpu(allow_cpu),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_q(ram_q),
    .cpu_changed(cpu_changed)
`ifdef NVRAM_DIRTY_TRACK_EN
    , .dirty_clr(dirty_clr), .dirty(dirty)
`endif
  );

  always #5 clk30 = ~clk30;

  // Single-port synchronous RAM
  logic [7:0] ram_mem [8192];
  always @(posedge clk30) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_q <= ram_mem[ram_addr];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-timeline model ----------------
  // A grant at edge g drives the RAM strobe for one cycle, the ack appears
  // after edge g+2, and the arbiter can grant again from edge g+3.
  logic [7:0]  shadow [8192];
  int          cyc = 0;
  int          done_cyc = 0;
  int          free_cyc = 0;
  bit          pend = 0;
  bit          srv_c = 0, srv_h = 0;
  bit          prio_h = 0;
  bit          t_hps = 0, t_we = 0;
  logic [12:0] t_addr = '0;
  logic [7:0]  t_din = '0;
  logic        e_cpu_ack = 0, e_hps_ack = 0, e_chg = 0, e_we = 0;
  logic [7:0]  e_cpu_dout = '0, e_hps_dout = '0, e_din = '0;
  logic [12:0] e_addr = '0;

  always @(posedge clk30 or posedge reset) begin
    if (reset) begin
      pend = 0; free_cyc = cyc; srv_c = 0; srv_h = 0; prio_h = 0;
      e_cpu_ack = 0; e_hps_ack = 0; e_chg = 0; e_we = 0;
      e_cpu_dout = '0; e_hps_dout = '0; e_din = '0; e_addr = '0;
    end else begin
      bit el_c, el_h, win_h;
      logic [7:0] data;
      cyc = cyc + 1;
      e_cpu_ack = 0; e_hps_ack = 0; e_chg = 0; e_we = 0;
      el_c = cpu_req && !srv_c && allow_cpu;
      el_h = hps_req && !srv_h;
      if (pend && cyc == done_cyc) begin
        pend = 0;
        data = t_we ? t_din : shadow[t_addr];
        if (t_we) shadow[t_addr] = t_din;
        if (t_hps) begin
          e_hps_dout = data; e_hps_ack = 1; srv_h = 1;
        end else begin
          e_cpu_dout = data; e_cpu_ack = 1; e_chg = t_we; srv_c = 1;
        end
      end else if (cyc >= free_cyc && (el_c || el_h)) begin
        win_h = el_h && (!el_c || prio_h);
        if (el_c && el_h) prio_h = !win_h;
        t_hps  = win_h;
        t_we   = win_h ? hps_we : cpu_we;
        t_addr = win_h ? hps_addr : cpu_addr;
        t_din  = win_h ? hps_din : cpu_din;
        e_we = t_we; e_addr = t_addr; e_din = t_din;
        pend = 1; done_cyc = cyc + 2; free_cyc = cyc + 3;
      end
      if (!cpu_req) srv_c = 0;
      if (!hps_req) srv_h = 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk30) begin
    check("cpu_ack", 16'(cpu_ack), 16'(e_cpu_ack));
    check("hps_ack", 16'(hps_ack), 16'(e_hps_ack));
    check("cpu_changed", 16'(cpu_changed), 16'(e_chg));
    check("cpu_dout", 16'(cpu_dout), 16'(e_cpu_dout));
    check("hps_dout", 16'(hps_dout), 16'(e_hps_dout));
    check("ram_we", 16'(ram_we), 16'(e_we));
    check("ram_addr", 16'(ram_addr), 16'(e_addr));
    check("ram_din", 16'(ram_din), 16'(e_din));
  end

  task automatic tick();
    @(posedge clk30);
    #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    logic [7:0] seen;
    for (int i = 0; i < 8192; i++) begin
      ram_mem[i] = '0;
      shadow[i]  = '0;
    end
    repeat (3) tick();
    check("rst_ram_we", 16'(ram_we), 16'h0);
    check("rst_ram_addr", 16'(ram_addr), 16'h0);
    check("rst_cpu_ack", 16'(cpu_ack), 16'h0);
    check("rst_cpu_dout", 16'(cpu_dout), 16'h0);
    reset = 1'b0;
    tick();

    // CPU write 0x0123 = 0xA5
    cpu_we = 1; cpu_addr = 13'h0123; cpu_din = 8'hA5; cpu_req = 1;
    tick();
    check("wr_ram_we_hi", 16'(ram_we), 16'h1);
    check("wr_ram_addr", 16'(ram_addr), 16'h0123);
    check("wr_ram_din", 16'(ram_din), 16'h00A5);
    tick();
    check("wr_ram_we_lo", 16'(ram_we), 16'h0);
    check("wr_no_ack_yet", 16'(cpu_ack), 16'h0);
    tick();
    check("wr_cpu_ack", 16'(cpu_ack), 16'h1);
    check("wr_changed", 16'(cpu_changed), 16'h1);
    check("wr_dout", 16'(cpu_dout), 16'h00A5);
`ifdef NVRAM_DIRTY_TRACK_EN
    dirty_clr = 1;
`endif
    cpu_req = 0;
    tick();
    check("wr_ack_drop", 16'(cpu_ack), 16'h0);
    check("wr_changed_drop", 16'(cpu_changed), 16'h0);
`ifdef NVRAM_DIRTY_TRACK_EN
    check("dirty_set_wins", 16'(dirty), 16'h1);
    tick();
    check("dirty_cleared", 16'(dirty), 16'h0);
    dirty_clr = 0;
`endif

    // CPU read back 0x0123
    cpu_we = 0; cpu_din = 8'h00; cpu_req = 1;
    tick();
    check("rd_ram_we", 16'(ram_we), 16'h0);
    tick(); tick();
    check("rd_cpu_ack", 16'(cpu_ack), 16'h1);
    check("rd_dout", 16'(cpu_dout), 16'h00A5);
    check("rd_changed", 16'(cpu_changed), 16'h0);
    cpu_req = 0;
    tick();

    // Tie after reset: CPU first, then HPS
    hps_we = 0; hps_addr = 13'h0010; cpu_addr = 13'h0123;
    cpu_req = 1; hps_req = 1;
    tick(); tick(); tick();
    check("tie1_cpu_ack", 16'(cpu_ack), 16'h1);
    check("tie1_hps_wait", 16'(hps_ack), 16'h0);
    cpu_req = 0;
    tick(); tick(); tick();
    check("tie1_hps_ack", 16'(hps_ack), 16'h1);
    check("tie1_hps_dout", 16'(hps_dout), 16'h0);
    hps_req = 0;
    tick();
    // Fresh tie: HPS first
    cpu_req = 1; hps_req = 1;
    tick(); tick(); tick();
    check("tie2_hps_ack", 16'(hps_ack), 16'h1);
    check("tie2_cpu_wait", 16'(cpu_ack), 16'h0);
    hps_req = 0;
    tick(); tick(); tick();
    check("tie2_cpu_ack", 16'(cpu_ack), 16'h1);
    cpu_req = 0;
    tick();

    // Held request is acknowledged once; a 1-cycle drop re-arms it
    cpu_req = 1; acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    check("held_one_ack", 16'(acks), 16'h1);
    cpu_req = 0;
    tick();
    cpu_req = 1; acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    check("rearm_ack", 16'(acks), 16'h1);
    cpu_req = 0;
    tick();

    // allow_cpu gating while HPS writes 0x1FFF = 0x3C
    allow_cpu = 0; cpu_we = 0; cpu_addr = 13'h1FFF; cpu_req = 1;
    hps_we = 1; hps_addr = 13'h1FFF; hps_din = 8'h3C; hps_req = 1;
    tick(); tick(); tick();
    check("gate_hps_ack", 16'(hps_ack), 16'h1);
    check("gate_hps_dout", 16'(hps_dout), 16'h003C);
    check("gate_cpu_ack", 16'(cpu_ack), 16'h0);
    check("gate_no_changed", 16'(cpu_changed), 16'h0);
    hps_req = 0; hps_we = 0;
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    check("gate_blocked", 16'(acks), 16'h0);
    allow_cpu = 1; acks = 0; seen = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_ack) begin
        acks++;
        seen = cpu_dout;
      end
    end
    check("ungate_ack", 16'(acks), 16'h1);
    check("ungate_dout", 16'(seen), 16'h003C);
    cpu_req = 0;
    tick();

    // Reset during ACCESS of a CPU write
    cpu_we = 1; cpu_addr = 13'h0055; cpu_din = 8'h77; cpu_req = 1;
    tick();
    check("pre_rst_we", 16'(ram_we), 16'h1);
    reset = 1;
    #1;
    check("rst_async_we", 16'(ram_we), 16'h0);
    check("rst_async_addr", 16'(ram_addr), 16'h0);
    cpu_req = 0; cpu_we = 0;
    tick();
    reset = 0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    check("rst_no_ack", 16'(acks), 16'h0);
    // The aborted write must not have reached the RAM
    cpu_req = 1;
    tick(); tick(); tick();
    check("rst_rd_ack", 16'(cpu_ack), 16'h1);
    check("rst_rd_dout", 16'(cpu_dout), 16'h0);
    cpu_req = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
